spi_burst_sequencer: RTL



---
 rtl/spi_seq_pkg.sv | 34 +++
 rtl/byte_fifo.sv | 48 ++++
 rtl/spi_burst_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared register map, bit positions and state encoding
// for the SPI burst sequencer.
package spi_seq_pkg;

  localparam logic [1:0] CPU_DATA = 2'd0;
  localparam logic [1:0] CPU_STAT = 2'd1;
  localparam logic [1:0] CPU_CNT  = 2'd2;
  localparam logic [1:0] CPU_CTRL = 2'd3;

  localparam logic [1:0] TGT_CTRL = 2'd3;
  localparam logic [1:0] TGT_TX   = 2'd2;
  localparam logic [1:0] TGT_RX   = 2'd1;
  localparam int         TGT_BUSY = 7;

  localparam int ST_OVF  = 7;
  localparam int ST_DONE = 5;

  localparam int CT_IRQ   = 4;
  localparam int CT_ABORT = 3;
  localparam int CT_FILL  = 2;
  localparam int CT_KEEP  = 1;
  localparam int CT_START = 0;

  typedef enum logic [2:0] {
    IDLE,
    CS_ON,
    LOAD,
    POLL,
    FETCH,
    FINISH,
    GAP
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO; push and pop may
// coincide, a push when full or a pop when empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// CPU-programmed burst engine that drives spi_controller's
// register port one byte at a time, buffering TX and RX.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cs,
  input  logic       i_rwb,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_ctl_cs,
  output logic       o_ctl_rwb,
  output logic [1:0] o_ctl_addr,
  output logic [7:0] o_ctl_data,
  input  logic [7:0] i_ctl_data,
  output logic       o_irq
);

  state_t     state;
  state_t     acc;
  logic [8:0] remaining;
  logic [7:0] count;
  logic       irq_en;
  logic       fill;
  logic       keep_cs;
  logic       abort_pend;
  logic       done;
  logic       ovf;

  logic       cpu_wr;
  logic       cpu_rd;
  logic       ctrl_wr;
  logic       busy;
  logic       start;
  logic       unused_bit;

  logic       tx_push;
  logic       tx_pop;
  logic [7:0] tx_dout;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_push;
  logic       rx_pop;
  logic [7:0] rx_dout;
  logic       rx_full;
  logic       rx_empty;

  assign cpu_wr     = i_cs & ~i_rwb;
  assign cpu_rd     = i_cs & i_rwb;
  assign ctrl_wr    = cpu_wr && (i_addr == CPU_CTRL);
  assign busy       = (state != IDLE);
  assign start      = ctrl_wr & i_data[CT_START] & ~busy;
  assign unused_bit = i_data[6];

  assign tx_push = cpu_wr && (i_addr == CPU_DATA);
  assign tx_pop  = (state == LOAD) && !tx_empty;
  assign rx_pop  = cpu_rd && (i_addr == CPU_DATA);
  // i_ctl_data is valid while the RX read is on the bus
  assign rx_push = (state == GAP) && (acc == FETCH);

  assign o_irq = done & irq_en;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (tx_push),
    .din   (i_data),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (rx_push),
    .din   (i_ctl_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    o_data = 8'h00;
    unique case (i_addr)
      CPU_DATA: o_data = rx_empty ? 8'h00 : rx_dout;
      CPU_STAT: o_data = {ovf, 1'b0, done, rx_empty,
                          rx_full, tx_empty, tx_full, busy};
      CPU_CNT:  o_data = count;
      CPU_CTRL: o_data = {3'b000, irq_en, 1'b0,
                          fill, keep_cs, busy};
      default:  o_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      acc        <= IDLE;
      remaining  <= '0;
      count      <= '0;
      irq_en     <= 1'b0;
      fill       <= 1'b0;
      keep_cs    <= 1'b0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      o_ctl_cs   <= 1'b0;
      o_ctl_rwb  <= 1'b1;
      o_ctl_addr <= '0;
      o_ctl_data <= '0;
    end else begin
      if (tx_push && tx_full) ovf <= 1'b1;
      if (cpu_wr && (i_addr == CPU_STAT)) begin
        if (i_data[ST_OVF])  ovf  <= 1'b0;
        if (i_data[ST_DONE]) done <= 1'b0;
      end
      if (cpu_wr && (i_addr == CPU_CNT) && !busy)
        count <= i_data;
      if (ctrl_wr) begin
        irq_en  <= i_data[CT_IRQ];
        fill    <= i_data[CT_FILL];
        keep_cs <= i_data[CT_KEEP];
        if (i_data[CT_ABORT] && busy)
          abort_pend <= 1'b1;
      end

      o_ctl_cs <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining  <= (count == 8'd0) ? 9'd256
                                          : {1'b0, count};
            done       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= CS_ON;
          end
        end
        CS_ON: begin
          o_ctl_cs   <= 1'b1;
          o_ctl_rwb  <= 1'b0;
          o_ctl_addr <= TGT_CTRL;
          o_ctl_data <= 8'h01;
          acc        <= CS_ON;
          state      <= GAP;
        end
        LOAD: begin
          if (!tx_empty || fill) begin
            o_ctl_cs   <= 1'b1;
            o_ctl_rwb  <= 1'b0;
            o_ctl_addr <= TGT_TX;
            o_ctl_data <= tx_empty ? FILL_BYTE : tx_dout;
            acc        <= LOAD;
            state      <= GAP;
          end
        end
        POLL: begin
          o_ctl_cs   <= 1'b1;
          o_ctl_rwb  <= 1'b1;
          o_ctl_addr <= TGT_CTRL;
          acc        <= POLL;
          state      <= GAP;
        end
        FETCH: begin
          if (!rx_full) begin
            o_ctl_cs   <= 1'b1;
            o_ctl_rwb  <= 1'b1;
            o_ctl_addr <= TGT_RX;
            acc        <= FETCH;
            state      <= GAP;
          end
        end
        FINISH: begin
          if (keep_cs) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            o_ctl_cs   <= 1'b1;
            o_ctl_rwb  <= 1'b0;
            o_ctl_addr <= TGT_CTRL;
            o_ctl_data <= 8'h00;
            acc        <= FINISH;
            state      <= GAP;
          end
        end
        GAP: begin
          unique case (acc)
            CS_ON: state <= LOAD;
            LOAD:  state <= POLL;
            POLL:  state <= i_ctl_data[TGT_BUSY] ? POLL
                                                 : FETCH;
            FETCH: begin
              remaining <= remaining - 9'd1;
              state <= (remaining == 9'd1 || abort_pend)
                       ? FINISH : LOAD;
            end
            default: begin
              done  <= 1'b1;
              state <= IDLE;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
